// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit: memory command codes,
// access sizes, bus widths and the FSM state encoding.
package load_store_unit_pkg;

  localparam int unsigned W_CPU     = 32;
  localparam int unsigned W_BE      = W_CPU / 8;
  localparam int unsigned W_MEM_CMD = 2;
  localparam int unsigned W_SIZE    = 2;
  localparam int unsigned W_LSU_ST  = 2;

  localparam logic [W_MEM_CMD-1:0] MEM_NOP   = 2'd0;
  localparam logic [W_MEM_CMD-1:0] MEM_READ  = 2'd1;
  localparam logic [W_MEM_CMD-1:0] MEM_WRITE = 2'd2;

  localparam logic [W_SIZE-1:0] SIZE_B = 2'd0;
  localparam logic [W_SIZE-1:0] SIZE_H = 2'd1;
  localparam logic [W_SIZE-1:0] SIZE_W = 2'd2;

  typedef enum logic [W_LSU_ST-1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_st_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: valid/ready request channel plus a valid-only response
// channel. master = load/store unit, slave = data memory.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic             m_req_valid;
  logic             m_req_ready;
  logic             m_we;
  logic [W_CPU-1:0] m_addr;
  logic [W_BE-1:0]  m_be;
  logic [W_CPU-1:0] m_wdata;
  logic             m_rsp_valid;
  logic [W_CPU-1:0] m_rdata;

  modport master (
    output m_req_valid, m_we, m_addr, m_be, m_wdata,
    input  m_req_ready, m_rsp_valid, m_rdata
  );

  modport slave (
    input  m_req_valid, m_we, m_addr, m_be, m_wdata,
    output m_req_ready, m_rsp_valid, m_rdata
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering.
//   in : lane (addr[1:0]), size, load_sign, wdata (right-justified), rdata_raw
//   out: be_c, st_data_c (lane-replicated), ld_data_c (extended), misaligned_c
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic [W_SIZE-1:0] size,
  input  logic              load_sign,
  input  logic [W_CPU-1:0]  wdata,
  input  logic [W_CPU-1:0]  rdata_raw,
  output logic [W_BE-1:0]   be_c,
  output logic [W_CPU-1:0]  st_data_c,
  output logic [W_CPU-1:0]  ld_data_c,
  output logic              misaligned_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_raw[{lane, 3'b000} +: 8];
  assign half_v = rdata_raw[{lane[1], 4'b0000} +: 16];

  always_comb begin
    be_c         = '0;
    st_data_c    = '0;
    ld_data_c    = '0;
    misaligned_c = 1'b0;
    case (size)
      SIZE_B: begin
        be_c      = 4'b0001 << lane;
        st_data_c = {4{wdata[7:0]}};
        ld_data_c = {{(W_CPU-8){load_sign & byte_v[7]}}, byte_v};
      end
      SIZE_H: begin
        misaligned_c = lane[0];
        be_c         = 4'b0011 << {lane[1], 1'b0};
        st_data_c    = {2{wdata[15:0]}};
        ld_data_c    = {{(W_CPU-16){load_sign & half_v[15]}}, half_v};
      end
      SIZE_W: begin
        misaligned_c = |lane;
        be_c         = 4'b1111;
        st_data_c    = wdata;
        ld_data_c    = rdata_raw;
      end
      default: misaligned_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a core memory command into one valid/ready
// transaction on the data memory, stalls the core until it completes and
// returns extended load data plus an error flag for one cycle in DONE.
//   clk, rst (async, active-low)
//   core side: mem_cmd, size, load_sign, addr, wdata -> rdata, stall, err
//   mem       : load_store_unit_if.master
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_MEM_CMD-1:0] mem_cmd,
  input  logic [W_SIZE-1:0]    size,
  input  logic                 load_sign,
  input  logic [W_CPU-1:0]     addr,
  input  logic [W_CPU-1:0]     wdata,
  output logic [W_CPU-1:0]     rdata,
  output logic                 stall,
  output logic                 err,
  load_store_unit_if.master    mem
);

  localparam int unsigned W_CNT = 8;

  lsu_st_e           state;
  logic [W_CNT-1:0]  cnt;
  logic [1:0]        lane_q;
  logic [W_SIZE-1:0] size_q;
  logic              sign_q;

  logic [1:0]        al_lane;
  logic [W_SIZE-1:0] al_size;
  logic              al_sign;
  logic [W_BE-1:0]   be_c;
  logic [W_CPU-1:0]  st_data_c;
  logic [W_CPU-1:0]  ld_data_c;
  logic              misaligned_c;
  logic              timeout_c;

  // Live core inputs decide the request in IDLE; latched copies steer the load data later.
  assign al_lane = (state == LSU_IDLE) ? addr[1:0] : lane_q;
  assign al_size = (state == LSU_IDLE) ? size      : size_q;
  assign al_sign = (state == LSU_IDLE) ? load_sign : sign_q;

  load_store_unit_lane_align u_align (
    .lane         (al_lane),
    .size         (al_size),
    .load_sign    (al_sign),
    .wdata        (wdata),
    .rdata_raw    (mem.m_rdata),
    .be_c         (be_c),
    .st_data_c    (st_data_c),
    .ld_data_c    (ld_data_c),
    .misaligned_c (misaligned_c)
  );

  assign timeout_c = (cnt >= W_CNT'(TIMEOUT - 1));

  // Stall rises in the same cycle a command appears; gated low while in reset.
  assign stall = rst & (((state == LSU_IDLE) && (mem_cmd != MEM_NOP)) ||
                        (state == LSU_REQ) || (state == LSU_RSP));

  // FSM, timeout counter and registered request/response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= LSU_IDLE;
      cnt             <= '0;
      lane_q          <= '0;
      size_q          <= '0;
      sign_q          <= 1'b0;
      rdata           <= '0;
      err             <= 1'b0;
      mem.m_req_valid <= 1'b0;
      mem.m_we        <= 1'b0;
      mem.m_addr      <= '0;
      mem.m_be        <= '0;
      mem.m_wdata     <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (mem_cmd != MEM_NOP) begin
            if (misaligned_c) begin
              state <= LSU_DONE;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state           <= LSU_REQ;
              cnt             <= '0;
              lane_q          <= addr[1:0];
              size_q          <= size;
              sign_q          <= load_sign;
              mem.m_req_valid <= 1'b1;
              mem.m_we        <= (mem_cmd == MEM_WRITE);
              mem.m_addr      <= {addr[W_CPU-1:2], 2'b00};
              mem.m_be        <= be_c;
              mem.m_wdata     <= st_data_c;
            end
          end
        end
        LSU_REQ: begin
          if (mem.m_req_ready && mem.m_rsp_valid) begin
            state           <= LSU_DONE;
            mem.m_req_valid <= 1'b0;
            rdata           <= mem.m_we ? '0 : ld_data_c;
          end else if (mem.m_req_ready) begin
            state           <= LSU_RSP;
            mem.m_req_valid <= 1'b0;
            cnt             <= cnt + W_CNT'(1);
          end else if (timeout_c) begin
            state           <= LSU_DONE;
            mem.m_req_valid <= 1'b0;
            err             <= 1'b1;
            rdata           <= '0;
          end else begin
            cnt <= cnt + W_CNT'(1);
          end
        end
        LSU_RSP: begin
          if (mem.m_rsp_valid) begin
            state <= LSU_DONE;
            rdata <= mem.m_we ? '0 : ld_data_c;
          end else if (timeout_c) begin
            state <= LSU_DONE;
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            cnt <= cnt + W_CNT'(1);
          end
        end
        default: begin
          // DONE: result visible for exactly one cycle.
          state <= LSU_IDLE;
          rdata <= '0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: zero-wait loads, sign/zero extension,
// a delayed-ack store, misalignment, request timeout and mid-access reset.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [W_MEM_CMD-1:0] mem_cmd;
  logic [W_SIZE-1:0]    size;
  logic                 load_sign;
  logic [W_CPU-1:0]     addr;
  logic [W_CPU-1:0]     wdata;
  logic [W_CPU-1:0]     rdata;
  logic                 stall;
  logic                 err;

  int n_assert = 0;
  int n_fail   = 0;

  load_store_unit_if mem_if ();

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .mem_cmd   (mem_cmd),
    .size      (size),
    .load_sign (load_sign),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .err       (err),
    .mem       (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W_MEM_CMD-1:0] c, input logic [W_SIZE-1:0] s,
                       input logic [31:0] a, input logic [31:0] wd, input logic sg);
    mem_cmd   = c;
    size      = s;
    addr      = a;
    wdata     = wd;
    load_sign = sg;
  endtask

  // Zero-wait read: ready during REQ, response in the first RSP cycle.
  task automatic read_zero_wait(input logic [W_SIZE-1:0] s, input logic [31:0] a,
                                input logic sg, input logic [31:0] data,
                                output logic [31:0] rd, output logic e);
    step();
    issue(MEM_READ, s, a, 32'h0, sg);
    mem_if.m_req_ready = 1'b1;
    step();
    step();
    mem_if.m_rsp_valid = 1'b1;
    mem_if.m_rdata     = data;
    step();
    mem_if.m_rsp_valid = 1'b0;
    mem_cmd            = MEM_NOP;
    @(negedge clk);
    rd = rdata;
    e  = err;
    step();
  endtask

  logic [31:0] rd_v;
  logic        e_v;
  int          req_cycles;

  initial begin
    rst                = 1'b0;
    issue(MEM_NOP, SIZE_W, 32'h0, 32'h0, 1'b0);
    mem_if.m_req_ready = 1'b0;
    mem_if.m_rsp_valid = 1'b0;
    mem_if.m_rdata     = 32'h0;

    // Reset state, stall gated even with a pending command.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(mem_if.m_req_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_addr", mem_if.m_addr, 32'h0);
    mem_cmd = MEM_READ;
    #1;
    chk("rst_stall_gated", 32'(stall), 32'h0);
    mem_cmd = MEM_NOP;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'h0);

    // 1: zero-wait lw 0x104.
    step();
    issue(MEM_READ, SIZE_W, 32'h104, 32'h0, 1'b0);
    mem_if.m_req_ready = 1'b1;
    @(negedge clk);
    chk("t1_idle_stall", 32'(stall), 32'h1);
    chk("t1_idle_valid", 32'(mem_if.m_req_valid), 32'h0);
    step();
    @(negedge clk);
    chk("t1_req_stall", 32'(stall), 32'h1);
    chk("t1_req_valid", 32'(mem_if.m_req_valid), 32'h1);
    chk("t1_req_addr", mem_if.m_addr, 32'h104);
    chk("t1_req_be", 32'(mem_if.m_be), 32'hF);
    chk("t1_req_we", 32'(mem_if.m_we), 32'h0);
    step();
    mem_if.m_rsp_valid = 1'b1;
    mem_if.m_rdata     = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_rsp_stall", 32'(stall), 32'h1);
    chk("t1_rsp_valid", 32'(mem_if.m_req_valid), 32'h0);
    step();
    mem_if.m_rsp_valid = 1'b0;
    mem_cmd            = MEM_NOP;
    @(negedge clk);
    chk("t1_done_stall", 32'(stall), 32'h0);
    chk("t1_done_rdata", rdata, 32'hDEADBEEF);
    chk("t1_done_err", 32'(err), 32'h0);
    step();
    @(negedge clk);
    chk("t1_after_rdata", rdata, 32'h0);

    // 2a: lb 0x103 sign-extended, ready and response in the same REQ cycle.
    step();
    issue(MEM_READ, SIZE_B, 32'h103, 32'h0, 1'b1);
    step();
    mem_if.m_rsp_valid = 1'b1;
    mem_if.m_rdata     = 32'h80112233;
    @(negedge clk);
    chk("t2_be", 32'(mem_if.m_be), 32'h8);
    chk("t2_addr", mem_if.m_addr, 32'h100);
    step();
    mem_if.m_rsp_valid = 1'b0;
    mem_cmd            = MEM_NOP;
    @(negedge clk);
    chk("t2_lb_stall", 32'(stall), 32'h0);
    chk("t2_lb_rdata", rdata, 32'hFFFFFF80);
    step();

    // 2b: lbu and lh on the same word.
    read_zero_wait(SIZE_B, 32'h103, 1'b0, 32'h80112233, rd_v, e_v);
    chk("t2_lbu_rdata", rd_v, 32'h00000080);
    chk("t2_lbu_err", 32'(e_v), 32'h0);
    read_zero_wait(SIZE_H, 32'h102, 1'b1, 32'h80112233, rd_v, e_v);
    chk("t2_lh_rdata", rd_v, 32'hFFFF8011);
    read_zero_wait(SIZE_H, 32'h100, 1'b0, 32'h80119233, rd_v, e_v);
    chk("t2_lhu_rdata", rd_v, 32'h00009233);

    // 3: sh 0x22, ack on the 5th RSP cycle.
    step();
    issue(MEM_WRITE, SIZE_H, 32'h22, 32'h1234ABCD, 1'b0);
    step();
    @(negedge clk);
    chk("t3_we", 32'(mem_if.m_we), 32'h1);
    chk("t3_be", 32'(mem_if.m_be), 32'hC);
    chk("t3_wdata", mem_if.m_wdata, 32'hABCDABCD);
    chk("t3_addr", mem_if.m_addr, 32'h20);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("t3_rsp_stall", 32'(stall), 32'h1);
      chk("t3_rsp_valid", 32'(mem_if.m_req_valid), 32'h0);
    end
    step();
    mem_if.m_rsp_valid = 1'b1;
    @(negedge clk);
    chk("t3_rsp5_stall", 32'(stall), 32'h1);
    step();
    mem_if.m_rsp_valid = 1'b0;
    mem_cmd            = MEM_NOP;
    @(negedge clk);
    chk("t3_done_stall", 32'(stall), 32'h0);
    chk("t3_done_err", 32'(err), 32'h0);
    chk("t3_done_rdata", rdata, 32'h0);
    step();

    // 4: misaligned lw 0x102.
    step();
    issue(MEM_READ, SIZE_W, 32'h102, 32'h0, 1'b0);
    @(negedge clk);
    chk("t4_idle_stall", 32'(stall), 32'h1);
    step();
    mem_cmd = MEM_NOP;
    @(negedge clk);
    chk("t4_done_stall", 32'(stall), 32'h0);
    chk("t4_done_err", 32'(err), 32'h1);
    chk("t4_done_rdata", rdata, 32'h0);
    chk("t4_done_valid", 32'(mem_if.m_req_valid), 32'h0);
    step();

    // 5: memory never ready -> timeout after 255 REQ cycles.
    step();
    mem_if.m_req_ready = 1'b0;
    issue(MEM_READ, SIZE_W, 32'h200, 32'h0, 1'b0);
    step();
    req_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem_if.m_req_valid) req_cycles++;
      if (!stall) break;
      step();
    end
    mem_cmd = MEM_NOP;
    chk("t5_done_reached", 32'(stall), 32'h0);
    chk("t5_req_cycles", 32'(req_cycles), 32'd255);
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_rdata", rdata, 32'h0);
    chk("t5_valid_drop", 32'(mem_if.m_req_valid), 32'h0);
    step();
    mem_if.m_req_ready = 1'b1;

    // 6: reset while in RSP, then a stray response.
    step();
    issue(MEM_READ, SIZE_W, 32'h300, 32'h0, 1'b0);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_stall", 32'(stall), 32'h0);
    chk("t6_rst_addr", mem_if.m_addr, 32'h0);
    chk("t6_rst_be", 32'(mem_if.m_be), 32'h0);
    chk("t6_rst_valid", 32'(mem_if.m_req_valid), 32'h0);
    step();
    rst                = 1'b1;
    mem_cmd            = MEM_NOP;
    mem_if.m_rsp_valid = 1'b1;
    mem_if.m_rdata     = 32'hCAFEF00D;
    @(negedge clk);
    chk("t6_late_stall", 32'(stall), 32'h0);
    step();
    mem_if.m_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t6_late_rdata", rdata, 32'h0);
    chk("t6_late_err", 32'(err), 32'h0);
    chk("t6_late_valid", 32'(mem_if.m_req_valid), 32'h0);
    read_zero_wait(SIZE_W, 32'h300, 1'b0, 32'h0BADF00D, rd_v, e_v);
    chk("t6_next_rdata", rd_v, 32'h0BADF00D);
    chk("t6_next_err", 32'(e_v), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
